// File: rtl/debounce_pkg.sv
// Shared timing constants and counter-width helper for the debouncer family.
package debounce_pkg;

    localparam int unsigned DEB_10MS_12MHZ = 120000;
    localparam int unsigned HOLD_1S_12MHZ  = 12000000;

    // Bits needed to hold 0..max_count; a zero count still gets a 1-bit vector.
    function automatic int cnt_width(input int unsigned max_count);
        return (max_count == 0) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-FF synchronizer, saturating stability counter,
// registered level, rise/fall strobes and a one-shot long-press strobe.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned MAX_CLK_COUNT  = DEB_10MS_12MHZ,
    parameter int unsigned HOLD_CLK_COUNT = HOLD_1S_12MHZ,
    parameter bit          ACTIVE_LOW     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic out,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam int              CW      = cnt_width(MAX_CLK_COUNT);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_CLK_COUNT);

    logic          x;
    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          rise_d;
    logic          fall_d;

    assign x      = sig ^ ACTIVE_LOW;
    assign accept = (s1 == s2) && (cnt == CNT_MAX);
    assign rise_d = accept & s2 & ~out;
    assign fall_d = accept & ~s2 & out;

    // NOTE: every register, synchronizer flops included, is cleared by the
    // synchronous reset so a held pin is re-qualified from scratch afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            out  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= x;
            s2   <= s1;
            rise <= rise_d;
            fall <= fall_d;
            if (s1 != s2) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (accept) begin
                out <= s2;
            end
        end
    end

    if (HOLD_CLK_COUNT > 0) begin : g_hold
        localparam int            HW        = cnt_width(HOLD_CLK_COUNT);
        localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CLK_COUNT - 1);

        logic [HW-1:0] hcnt;
        logic          hold_done;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hcnt      <= '0;
                hold_done <= 1'b0;
                hold      <= 1'b0;
            end else begin
                // NOTE: the strobe defaults low every cycle; only the firing
                // branch raises it, which keeps it a single-cycle pulse.
                hold <= 1'b0;
                if (!out || rise_d) begin
                    hcnt      <= '0;
                    hold_done <= 1'b0;
                end else if (hcnt != HOLD_LAST) begin
                    hcnt <= hcnt + HW'(1);
                end else if (!hold_done) begin
                    hold      <= 1'b1;
                    hold_done <= 1'b1;
                end
            end
        end
    end else begin : g_no_hold
        assign hold = 1'b0;
    end

endmodule

// File: rtl/debouncer_multi.sv
// NUM_CH independent debounce channels sharing one clock; all outputs are
// active-high regardless of pin polarity.
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int                NUM_CH         = 4,
    parameter int unsigned       MAX_CLK_COUNT  = DEB_10MS_12MHZ,
    parameter int unsigned       HOLD_CLK_COUNT = HOLD_1S_12MHZ,
    parameter logic [NUM_CH-1:0] ACTIVE_LOW     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] sig,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [NUM_CH-1:0] hold
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .MAX_CLK_COUNT  (MAX_CLK_COUNT),
            .HOLD_CLK_COUNT (HOLD_CLK_COUNT),
            .ACTIVE_LOW     (ACTIVE_LOW[i])
        ) u_channel (
            .clk   (clk),
            .rst_n (rst_n),
            .sig   (sig[i]),
            .out   (out[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .hold  (hold[i])
        );
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi with a sample-history reference model.
module tb_debouncer_multi;

    localparam int         NUM_CH = 2;
    localparam int         MAXC   = 4;
    localparam int         HOLDC  = 10;
    localparam logic [1:0] ACT    = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sig;
    logic [1:0] dut_out, dut_rise, dut_fall, dut_hold;

    debouncer_multi #(
        .NUM_CH         (NUM_CH),
        .MAX_CLK_COUNT  (MAXC),
        .HOLD_CLK_COUNT (HOLDC),
        .ACTIVE_LOW     (ACT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (sig),
        .out   (dut_out),
        .rise  (dut_rise),
        .fall  (dut_fall),
        .hold  (dut_hold)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_no = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_no, $time);
        end
    endtask

    // Reference model: a level is accepted once the pin has produced MAX+2
    // identical consecutive samples (reset counts as two zero samples); hold
    // fires HOLD edges after the rise edge if the level is still high.
    logic [1:0] exp_out, exp_rise, exp_fall, exp_hold;
    logic [1:0] m_x, m_prev;
    int         run_len [2];
    logic       last_x  [2];
    int         since   [2];
    bit         armed   [2];

    task automatic model_step();
        if (!rst_n) begin
            exp_out  = '0;
            exp_rise = '0;
            exp_fall = '0;
            exp_hold = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                run_len[ch] = 2;
                last_x[ch]  = 1'b0;
                since[ch]   = 0;
                armed[ch]   = 1'b0;
            end
        end else begin
            m_x      = sig ^ ACT;
            m_prev   = exp_out;
            exp_rise = '0;
            exp_fall = '0;
            exp_hold = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (run_len[ch] >= MAXC + 2) begin
                    exp_rise[ch] = last_x[ch] & ~m_prev[ch];
                    exp_fall[ch] = ~last_x[ch] & m_prev[ch];
                    exp_out[ch]  = last_x[ch];
                end
                if (!m_prev[ch]) begin
                    armed[ch] = 1'b0;
                end else if (armed[ch]) begin
                    since[ch]++;
                    if (since[ch] == HOLDC) begin
                        exp_hold[ch] = 1'b1;
                        armed[ch]    = 1'b0;
                    end
                end
                if (exp_rise[ch]) begin
                    armed[ch] = 1'b1;
                    since[ch] = 0;
                end
                if (m_x[ch] == last_x[ch]) begin
                    if (run_len[ch] < 1000) run_len[ch]++;
                end else begin
                    run_len[ch] = 1;
                    last_x[ch]  = m_x[ch];
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        edge_no++;
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("out",  dut_out,  exp_out);
            check("rise", dut_rise, exp_rise);
            check("fall", dut_fall, exp_fall);
            check("hold", dut_hold, exp_hold);
        end
    end

    // Channel-0 pulse tallies gathered by the stimulus process.
    int pr, pf, ph;

    task automatic clear_cnt();
        pr = 0;
        pf = 0;
        ph = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            pr += int'(dut_rise[0]);
            pf += int'(dut_fall[0]);
            ph += int'(dut_hold[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sig   = 2'b11;
        clear_cnt();

        // Reset with both pins driven high; ch1 is inverted so it reads low.
        tick(1);
        started = 1'b1;
        tick(2);
        check("rst_out",  dut_out,  2'b00);
        check("rst_rise", dut_rise, 2'b00);
        check("rst_hold", dut_hold, 2'b00);
        rst_n = 1'b1;
        tick(6);
        check("rel_out_e6", dut_out, 2'b00);
        tick(1);
        check("rel_out_e7",      dut_out,  2'b01);
        check("rel_rise_e7",     dut_rise, 2'b01);
        check("rel_model_rise",  exp_rise, 2'b01);
        tick(1);
        check("rel_rise_e8", dut_rise, 2'b00);

        // Clean press on ch0 followed by a long hold.
        sig = 2'b10;
        tick(12);
        check("press_idle", dut_out, 2'b00);
        sig = 2'b11;
        clear_cnt();
        tick(6);
        check("press_k5_out", dut_out, 2'b00);
        check("press_k5_pr",  pr, 0);
        tick(1);
        check("press_k6_out",  dut_out,  2'b01);
        check("press_k6_rise", dut_rise, 2'b01);
        tick(1);
        check("press_k7_rise", dut_rise, 2'b00);
        tick(8);
        check("hold_r9", dut_hold, 2'b00);
        tick(1);
        check("hold_r10",       dut_hold, 2'b01);
        check("hold_model_r10", exp_hold, 2'b01);
        tick(20);
        check("hold_once", ph, 1);
        check("press_pf",  pf, 0);
        check("press_pr",  pr, 1);

        // Bounce: 2-cycle toggles, then settle high.
        sig = 2'b10;
        tick(12);
        clear_cnt();
        sig = 2'b11; tick(2);
        sig = 2'b10; tick(2);
        sig = 2'b11; tick(2);
        sig = 2'b10; tick(2);
        sig = 2'b11;
        tick(6);
        check("bounce_pr_quiet", pr, 0);
        check("bounce_out_k5",   dut_out, 2'b00);
        tick(1);
        check("bounce_out_k6", dut_out, 2'b01);
        check("bounce_pr",     pr, 1);

        // Glitch of 3 cycles while the level is low.
        sig = 2'b10;
        tick(12);
        clear_cnt();
        sig = 2'b11; tick(3);
        sig = 2'b10; tick(12);
        check("glitch_pr",  pr, 0);
        check("glitch_pf",  pf, 0);
        check("glitch_out", dut_out, 2'b00);

        // Short press released before the hold point.
        clear_cnt();
        sig = 2'b11; tick(6);
        sig = 2'b10; tick(20);
        check("short_pr", pr, 1);
        check("short_pf", pf, 1);
        check("short_ph", ph, 0);

        // Both channels rise together; reset lands mid-hold.
        sig = 2'b01;
        tick(6);
        check("par_out_k5", dut_out, 2'b00);
        tick(1);
        check("par_rise", dut_rise, 2'b11);
        check("par_out",  dut_out,  2'b11);
        clear_cnt();
        tick(4);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_out",  dut_out,  2'b00);
        check("mid_rst_rise", dut_rise, 2'b00);
        check("mid_rst_fall", dut_fall, 2'b00);
        check("mid_rst_hold", dut_hold, 2'b00);
        tick(1);
        rst_n = 1'b1;
        tick(6);
        check("reacc_out_e6", dut_out, 2'b00);
        tick(1);
        check("reacc_out_e7",  dut_out,  2'b11);
        check("reacc_rise_e7", dut_rise, 2'b11);
        tick(9);
        check("reacc_hold_r9", dut_hold, 2'b00);
        check("reacc_ph_none", ph, 0);
        tick(1);
        check("reacc_hold_r10", dut_hold, 2'b11);
        tick(15);
        check("reacc_ph_once", ph, 1);

        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- Parametrised successor to the single-input debouncer: debounces NUM_CH independent asynchronous inputs, such as buttons or switches, in one clock domain. No clock divider.
- Per channel: 2-FF synchronizer, stability counter, debounced level, one-cycle rise/fall strobes, and a one-shot long-press (hold) strobe.
- Sits between board pins and user logic (counters, FSMs); replaces ad-hoc per-button instances.

Parameters:
- NUM_CH, 4, number of independent channels (>=1).
- MAX_CLK_COUNT, 120000, cycles an input must stay stable before it is accepted (10 ms at 12 MHz; >=1).
- HOLD_CLK_COUNT, 12000000, cycles the debounced level must stay active before the hold strobe fires (1 s at 12 MHz; 0 disables hold).
- ACTIVE_LOW, {NUM_CH{1'b0}}, per-channel mask; bit=1 means the raw pin is inverted before the synchronizer, so all outputs are active-high.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- sig  in  NUM_CH  raw asynchronous inputs, one bit per channel.
- out  out  NUM_CH  debounced level per channel, registered.
- rise  out  NUM_CH  one-cycle strobe when out[i] goes 0->1.
- fall  out  NUM_CH  one-cycle strobe when out[i] goes 1->0.
- hold  out  NUM_CH  one-cycle strobe when out[i] has been 1 for HOLD_CLK_COUNT cycles.

Behaviour:
- Counter widths: CW=$clog2(MAX_CLK_COUNT+1); HW=$clog2(HOLD_CLK_COUNT+1). The counters saturate and never wrap.
- Reset, while rst_n=0 at an edge, for every channel: s1=0, s2=0, cnt=0, out=0, rise=0, fall=0, hold=0, hcnt=0, hold_done=0.
- Input stage per channel: x = sig[i] ^ ACTIVE_LOW[i]. Then s1<=x and s2<=s1.
- Stability counter, evaluated on every edge in priority order:
  - if s1!=s2: cnt<=0.
  - else if cnt<MAX_CLK_COUNT: cnt<=cnt+1.
  - else (cnt==MAX_CLK_COUNT): out<=s2.
- Latency: if s1 first captures a new level at edge k and x stays stable, out changes at edge k+MAX_CLK_COUNT+2.
- Glitches: any s1/s2 mismatch restarts the count. A glitch shorter than MAX_CLK_COUNT+1 cycles never reaches out.
- Strobes:
  - rise<= accept & s2 & ~out.
  - fall<= accept & ~s2 & out.
  - accept = (s1==s2) && (cnt==MAX_CLK_COUNT).
  - The strobe is asserted on the same edge at which out updates. It is high for exactly one cycle per transition.
  - rise and fall are never both set on one channel.
- Hold logic, only when HOLD_CLK_COUNT>0:
  - If out==0 or rise asserted this cycle: hcnt<=0, hold_done<=0.
  - Else if hcnt<HOLD_CLK_COUNT-1: hcnt<=hcnt+1.
  - Else if !hold_done: hold<=1, hold_done<=1.
  - hold is 0 on every other cycle.
  - hold fires once per press, exactly HOLD_CLK_COUNT cycles after the rise strobe. It does not repeat.
  - Release before that point: no hold strobe.
  - If HOLD_CLK_COUNT==0, hold is tied to 0.
- Channels are fully independent; simultaneous events on different channels are reported in the same cycle.
- Reset mid-operation (mid-count or mid-hold): all state returns to reset values on that edge. A held input is re-accepted, with a rise strobe, MAX_CLK_COUNT+3 edges after rst_n returns high.
- Steady state: a level already equal to out at cnt==MAX_CLK_COUNT produces no strobe, and cnt stays saturated.

Decomposition:
- Shared package debounce_pkg:
  - width helper constants (CW, HW derivation);
  - default timing constants DEB_10MS_12MHZ=120000 and HOLD_1S_12MHZ=12000000, reused by board tops.
- Sub-module debounce_channel: one channel (sync, counter, out, rise, fall, hold) with scalar ports and the same parameters plus a 1-bit ACTIVE_LOW.
- debouncer_multi is a generate loop of NUM_CH debounce_channel instances.

Test Plan (NUM_CH=2, MAX_CLK_COUNT=4, HOLD_CLK_COUNT=10, ACTIVE_LOW=2'b10, clk period 10 ns):
1. Reset: hold rst_n=0 for 3 edges with sig=2'b11 -> out, rise, fall, hold all 0 during reset. After release, ch1 (inverted) stays 0. ch0 rises at edge 7 after rst_n high, with one rise pulse.
2. Clean press on ch0: sig[0] 0->1, captured by s1 at edge k -> out[0]=1 and rise[0]=1 at edge k+6; rise[0]=0 at k+7; fall never set.
3. Bounce on ch0: sig[0] toggles 1,0,1,0 with 2-cycle periods, then stays 1 -> no strobe during bouncing. A single rise occurs 6 edges after the final toggle is captured.
4. Glitch rejection: 3-cycle high pulse on sig[0] while out[0]=0 -> out[0] stays 0; rise and fall stay 0.
5. Long press: ch0 held high -> hold[0]=1 for one cycle exactly 10 cycles after rise[0], then no further hold. Release after 6 cycles of a new press -> fall strobe only, no hold.
6. Inversion and parallelism with mid-run reset: sig[1] 1->0 while sig[0] rises in the same cycle -> rise[1] and rise[0] assert on the same edge. Assert rst_n=0 mid-hold count -> hold never fires, and all outputs are 0 on the next edge.
